// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter: FSM state encoding, default
// RAM geometry and the port index constants used to record which requester
// owns the current transaction.
// -----------------------------------------------------------------------------
package dmem_pkg;

    // Default RAM geometry (word address / data width).
    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 16;

    // Requester indices, also the encoding of the grant / last-grant bits.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    // One transaction walks IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// -----------------------------------------------------------------------------
// dmem_arb_pick
// Combinational winner select between the CPU port (0) and the loader port (1).
//
// Build option:
//   DMEM_ARB_RR_EN defined   : round-robin; on a tie the port not granted last
//                              wins. Adds the last_gnt input.
//   DMEM_ARB_RR_EN undefined : fixed priority, port 0 always wins a tie.
//
// Ports:
//   req0, req1  in  : requests from port 0 / port 1
//   last_gnt    in  : port granted most recently (round-robin build only)
//   any_req     out : at least one request is pending
//   win         out : winning port index (meaningful only when any_req = 1)
// -----------------------------------------------------------------------------
module dmem_arb_pick
    import dmem_pkg::*;
(
    input  logic req0,
    input  logic req1,
`ifdef DMEM_ARB_RR_EN
    input  logic last_gnt,
`endif
    output logic any_req,
    output logic win
);

    always_comb begin
        any_req = req0 | req1;
`ifdef DMEM_ARB_RR_EN
        // A lone request always wins; only a tie consults the history.
        if (req0 && req1) begin
            win = ~last_gnt;
        end else if (req1) begin
            win = PORT_LDR;
        end else begin
            win = PORT_CPU;
        end
`else
        win = req0 ? PORT_CPU : PORT_LDR;
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data RAM between the CPU data port (port 0) and the
// program/IO loader (port 1). Each requester holds req/we/addr/wdata until its
// one-cycle ack. The arbiter registers the winner's address, data and write
// enable toward the RAM, waits out the RAM's one-cycle registered read latency
// and captures the RAM output into rdata. Writes also return the written word
// (the RAM reads new data during a write).
//
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration (see
// dmem_arb_pick); without it port 0 has fixed priority and no last-grant
// register exists.
//
// Ports:
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   req0/1, we0/1          : request and write flag per port
//   addr0/1, wdata0/1      : word address and write data per port
//   ack0/1                 : one-cycle completion pulse per port
//   rdata                  : read data, valid in the ack cycle (shared)
//   busy                   : transaction in flight (FSM not in IDLE)
//   ram_address/data/wren  : registered drive to the RAM
//   ram_q                  : RAM output, valid one cycle after the address
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,

    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,

    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    dmem_state_t       state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              ram_wren_q, ram_wren_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic any_req;
    logic win;

`ifdef DMEM_ARB_RR_EN
    logic last_gnt_q, last_gnt_d;
`endif

    dmem_arb_pick u_pick (
        .req0     (req0),
        .req1     (req1),
`ifdef DMEM_ARB_RR_EN
        .last_gnt (last_gnt_q),
`endif
        .any_req  (any_req),
        .win      (win)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d       = state_q;
        gnt_d         = gnt_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = ram_wren_q;
        rdata_d       = rdata_q;
`ifdef DMEM_ARB_RR_EN
        last_gnt_d    = last_gnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Requests are only looked at here; a losing request simply
                // stays high and wins a later pass through IDLE.
                if (any_req) begin
                    state_d       = ST_ISSUE;
                    gnt_d         = win;
                    ram_address_d = (win == PORT_LDR) ? addr1  : addr0;
                    ram_data_d    = (win == PORT_LDR) ? wdata1 : wdata0;
                    ram_wren_d    = (win == PORT_LDR) ? we1    : we0;
`ifdef DMEM_ARB_RR_EN
                    last_gnt_d    = win;
`endif
                end
            end
            ST_ISSUE: begin
                // The RAM takes the address (and any write) on the edge ending
                // this cycle; drop wren so a write lasts exactly one cycle.
                ram_wren_d = 1'b0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // ram_q now reflects the held address, including for writes.
                rdata_d = ram_q;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of order.
    // A write already registered into ram_wren_q still reaches the RAM on the
    // reset edge, since the RAM samples the pre-edge value; clearing it here
    // only stops any further write.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            gnt_q         <= PORT_CPU;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
            rdata_q       <= '0;
`ifdef DMEM_ARB_RR_EN
            // Port 1 marked as last grant so port 0 wins the first tie.
            last_gnt_q    <= PORT_LDR;
`endif
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
            rdata_q       <= rdata_d;
`ifdef DMEM_ARB_RR_EN
            last_gnt_q    <= last_gnt_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Acks decode straight from registered state, so they are one cycle wide
    // and mutually exclusive by construction.
    assign ack0        = (state_q == ST_ACK) && (gnt_q == PORT_CPU);
    assign ack1        = (state_q == ST_ACK) && (gnt_q == PORT_LDR);
    assign busy        = (state_q != ST_IDLE);
    assign rdata       = rdata_q;
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port SIMPLE data memory RAM (`SIMPLE_RAM_bb`) between two requesters: the CPU data port (port 0) and the program/IO loader port (port 1). Each requester issues read or write transactions through a req/ack handshake. The block arbitrates between them, sequences the RAM's address, data and write-enable around its one-cycle registered read latency, and returns read data with a single-cycle ack. It sits between the core's memory stage and the RAM instance and replaces direct opcode-driven write-enable control.

## Interface
- `ADDR_W`, default 8: RAM word-address width.
- `DATA_W`, default 16: RAM data width.
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req0`, `req1` in 1: request from port 0 (CPU) and port 1 (loader).
- `we0`, `we1` in 1: 1 = write, 0 = read. Valid while the matching `req` is high.
- `addr0`, `addr1` in `ADDR_W`: word address.
- `wdata0`, `wdata1` in `DATA_W`: write data.
- `ack0`, `ack1` out 1: one-cycle completion pulse.
- `rdata` out `DATA_W`: read data. Valid in the ack cycle; shared by both ports.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `ram_address` out `ADDR_W`: to RAM `.address`.
- `ram_data` out `DATA_W`: to RAM `.data`.
- `ram_wren` out 1: to RAM `.wren`.
- `ram_q` in `DATA_W`: from RAM `.q`; valid one cycle after the address is clocked into the RAM.

## Operation
- FSM states: IDLE → ISSUE → WAIT → ACK → IDLE. The state advances unconditionally except in IDLE.
- IDLE: requests are sampled only in this state.
  - If any `req` is high, the arbiter picks a winner and registers the winner's addr, wdata and we into `ram_address`, `ram_data` and `ram_wren`, records the winner as `gnt`, and goes to ISSUE.
  - Otherwise it stays in IDLE.
- ISSUE: the RAM captures `ram_address`. If `ram_wren` = 1, the write happens at the end of this cycle. Exit: `ram_wren` is cleared to 0, the address is held, go to WAIT.
- WAIT: `ram_q` is valid. `rdata` <= `ram_q` at the end of WAIT; this happens for writes too, so a write returns the freshly written word (RAM read-during-write returns new data). Go to ACK.
- ACK: `ack[gnt]` = 1 for exactly this cycle, and `rdata` is stable. Go to IDLE.
- Requester rules:
  - Hold `req`, `we`, `addr` and `wdata` stable from assertion until the ack cycle.
  - Deassert `req` or present a new transaction on the edge that ends ACK.
  - The loser's request stays pending and is served on the next pass through IDLE.
- Reset: state = IDLE, `ram_wren` = 0, `ram_address` = 0, `ram_data` = 0, `rdata` = 0, `ack0` = `ack1` = 0, `busy` = 0, last-grant = 1 (so port 0 wins the first tie).
  - Reset asserted mid-transaction aborts it with no ack.
  - A write whose ISSUE cycle coincides with reset still reaches the RAM, because `ram_wren` was already registered high. Only that one write can land.
- Widths: no arithmetic; addresses pass through unchanged.

## Timing
- Latency from IDLE sampling `req` (edge E0) to the ack cycle is 3 cycles: ISSUE after E0, WAIT after E1, ACK after E2.
- `ram_wren` is high for exactly one cycle per write and never high for reads.
- Throughput is one transaction per 4 cycles. Back-to-back requests from either port get no faster path.
- `busy` = (state != IDLE), driven combinationally from the state register.
- `ack0` and `ack1` are never high in the same cycle.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. On simultaneous requests the port not granted last wins. A lone request always wins. Last-grant updates on every grant.
- `DMEM_ARB_RR_EN` undefined: fixed priority, port 0 always wins. The last-grant register is not built, and port 1 may starve under continuous port-0 traffic.

## Structure
- Package `dmem_pkg`: FSM state enum (`ST_IDLE`, `ST_ISSUE`, `ST_WAIT`, `ST_ACK`), default `ADDR_W`/`DATA_W` localparams, port index constants `PORT_CPU` = 0 and `PORT_LDR` = 1.
- One sub-module, `dmem_arb_pick`: combinational winner select from `req0`, `req1` and last-grant, holding the `DMEM_ARB_RR_EN` conditional.
- The top level holds the FSM, the registered RAM drive and the `rdata` capture. `SIMPLE_RAM_bb` is instantiated by the parent, not inside this block.

## Test plan
- Reset, then idle: all outputs 0, `busy` = 0. Hold `reset` high while `req0` = 1: no ack is produced.
- Port 0 write addr 8'h05, data 16'hBEEF, then port 0 read addr 8'h05: `ram_wren` = 1 for one cycle only, `ack0` 3 cycles after sampling, `rdata` = 16'hBEEF.
- Port 1 write addr 8'hFF, data 16'h1234, then port 0 read addr 8'hFF: `ack1` then `ack0`, `rdata` = 16'h1234 (top-address boundary).
- Both ports request continuously with RR enabled: grants alternate 0,1,0,1. With RR disabled: port 0 only, and `ack1` never asserts.
- Assert reset during WAIT of a port 1 read: no `ack1`, state returns to IDLE, next request completes normally.
- Port 0 read immediately after its own ack (new `req` on the ACK-ending edge): sampled on the next IDLE, ack 4 cycles after the previous ack.
